seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter; the stimulus-side counterpart of the overlapping serial sequence detectors (e.g. the 1010 detector).
- Latches a parallel pattern, length, pass count and inter-pass gap on a start strobe.
- Emits the pattern MSB-first, one bit per clock, with valid/busy/done status, for driving detectors in-system and on benches.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of pat_len; must hold PAT_W.
- REP_W, 4, width of rep_cnt and passes_done.
- GAP_W, 3, width of gap_len.
- IDLE_BIT, 1'b0, value driven on out whenever valid=0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin transmission; sampled only in IDLE.
- abort  input  1  synchronous cancel of a transmission in progress.
- pattern  input  PAT_W  pattern bits; the lower pat_len bits are used, bit pat_len-1 is sent first.
- pat_len  input  LEN_W  bits per pass; legal range 1..PAT_W.
- rep_cnt  input  REP_W  number of passes; legal range 1..2^REP_W-1.
- gap_len  input  GAP_W  idle cycles between passes (0 = back-to-back).
- out  output  1  serial data.
- valid  output  1  out carries a pattern bit this cycle.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after the final bit.
- err  output  1  one-cycle pulse when a start is rejected.
- passes_done  output  REP_W  completed passes in the current or last transmission.

Behaviour:
- All outputs are registered. While reset=0: out=IDLE_BIT, valid=0, busy=0, done=0, err=0, passes_done=0, FSM=IDLE. Reset takes effect immediately, including mid-pass.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, start=1, inputs legal:
  - latch pattern, pat_len, rep_cnt, gap_len; clear passes_done.
  - next cycle: busy=1, valid=1, out=pattern[pat_len-1], bit_idx=pat_len-1; go to SHIFT.
- IDLE, start=1, illegal input (pat_len=0, pat_len>PAT_W, or rep_cnt=0): err=1 for one cycle, state unchanged, busy stays 0.
- SHIFT, bit_idx>0: decrement bit_idx; out = latched_pattern[bit_idx-1].
- SHIFT, bit_idx=0 (last bit of a pass): passes_done increments on that edge. Then:
  - passes remaining and gap>0: GAP, with valid=0, out=IDLE_BIT, gap counter = gap_len.
  - passes remaining and gap=0: restart at bit pat_len-1 on the next cycle with no bubble.
  - final pass: IDLE, with busy=0, valid=0, done=1 for exactly one cycle.
- GAP: lasts exactly gap_len cycles, busy=1, then SHIFT at bit pat_len-1.
- Busy duration = rep*len + (rep-1)*gap cycles. done is asserted in the cycle immediately after the last valid bit.
- start while busy: ignored; no err, no effect on latched values.
- Input changes while busy do not affect the transmission; only latched copies are used.
- abort=1 in SHIFT or GAP: next cycle IDLE, busy=0, valid=0, out=IDLE_BIT, done=0; passes_done holds its value.
- abort has priority over start; abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort is ignored and start is processed.
- done and a new start: start is sampled in the same cycle done is high (FSM already IDLE), so back-to-back transmissions have one idle cycle between them.
- passes_done saturates at rep_cnt. It holds its value after done until the next accepted start.

Test Plan:
- reset=0 asserted asynchronously mid-cycle -> out=0, valid=0, busy=0, done=0, passes_done=0 immediately; all hold until reset=1.
- pattern=8'h0A, pat_len=4, rep_cnt=1, gap_len=0, start pulse -> out=1,0,1,0 with valid=1 on 4 consecutive cycles; busy high 4 cycles; done=1 on cycle 5; passes_done=1.
- pattern=8'h0A, pat_len=4, rep_cnt=3, gap_len=0 -> 12 contiguous valid bits 101010101010; passes_done steps 1,2,3; done once; an attached overlapping 1010 detector fires 5 times.
- pattern=8'h0A, pat_len=4, rep_cnt=2, gap_len=2 -> 1010, two cycles valid=0/out=0, 1010; busy=10 cycles; done on cycle 11.
- Legality and contention:
  - pat_len=0 -> err pulse, busy=0.
  - pat_len=9 -> err pulse, busy=0.
  - rep_cnt=0 -> err pulse, busy=0.
  - start re-pulsed mid-transmission -> ignored, output sequence unchanged.
- Abort and reset recovery:
  - rep_cnt=3, abort during pass 2 bit 1 -> IDLE next cycle, no done, passes_done=1.
  - reset pulse during a pass, then start with pattern=8'hA5, pat_len=8 -> clean 10100101 sequence.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: latches a pattern/length/pass-count/gap on start
// and shifts the pattern out MSB-first with registered valid/busy/done/err status.
module seq_pattern_gen #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter int   GAP_W    = 3,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] passes_done,
  output logic [1:0]       state_dbg
);

  // Handshake: start is only looked at while busy=0; an accepted start raises busy
  // on the next cycle, a rejected one pulses err, and start while busy is dropped.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0] pd_q, pd_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             start_ok;
  logic [LEN_W-1:0] idx_m1;
  logic [REP_W-1:0] pd_inc;
  logic             last_pass;
  logic [PAT_W-1:0] start_sh;
  logic [PAT_W-1:0] shift_sh;
  logic [PAT_W-1:0] first_sh;

  assign start_ok  = (pat_len != '0) && (pat_len <= MAX_LEN) && (rep_cnt != '0);
  assign idx_m1    = bit_idx_q - LEN_W'(1);
  assign pd_inc    = pd_q + REP_W'(1);
  assign last_pass = (pd_inc == rep_q);
  // Bit selects are done by shifting so the index width never has to match PAT_W.
  assign start_sh  = pattern >> (pat_len - LEN_W'(1));
  assign shift_sh  = pat_q >> idx_m1;
  assign first_sh  = pat_q >> (len_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    pd_d      = pd_q;
    out_d     = out_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            pat_d     = pattern;
            len_d     = pat_len;
            rep_d     = rep_cnt;
            gap_d     = gap_len;
            pd_d      = '0;
            bit_idx_d = pat_len - LEN_W'(1);
            out_d     = start_sh[0];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = S_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          out_d   = IDLE_BIT;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = idx_m1;
          out_d     = shift_sh[0];
        end else begin
          pd_d = pd_inc;
          if (last_pass) begin
            state_d = S_IDLE;
            out_d   = IDLE_BIT;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
            out_d     = IDLE_BIT;
            valid_d   = 1'b0;
          end else begin
            bit_idx_d = len_q - LEN_W'(1);
            out_d     = first_sh[0];
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          out_d   = IDLE_BIT;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = S_SHIFT;
          bit_idx_d = len_q - LEN_W'(1);
          out_d     = first_sh[0];
          valid_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = IDLE_BIT;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      pd_q      <= '0;
      out_q     <= IDLE_BIT;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      pd_q      <= pd_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign out         = out_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign passes_done = pd_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: per-cycle expected status tuples are
// queued from a reference model of the transmission and compared at each negedge.
module tb_seq_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [3:0] rep_cnt;
  logic [2:0] gap_len;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] passes_done;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // tuple layout: {err, busy, valid, out, done, passes_done[3:0]}
  logic [8:0] exp_q[$];
  logic [8:0] obs;
  logic [8:0] e;

  logic [3:0] det_sh   = '0;
  int         det_hits = 0;

  seq_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .rep_cnt     (rep_cnt),
    .gap_len     (gap_len),
    .out         (out),
    .valid       (valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .passes_done (passes_done),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {err, busy, valid, out, done, passes_done};

  // overlapping 1010 detector fed only by valid bits of one transmission
  always @(negedge clk) begin
    if (!busy) begin
      det_sh <= '0;
    end else if (valid) begin
      det_sh <= {det_sh[2:0], out};
      if ({det_sh[2:0], out} == 4'b1010) det_hits <= det_hits + 1;
    end
  end

  // expected per-cycle tuples from the cycle after start through the done pulse
  task automatic push_expected(input logic [7:0] pat, input int len, input int rep,
                               input int gap);
    for (int r = 0; r < rep; r++) begin
      for (int b = len - 1; b >= 0; b--)
        exp_q.push_back({1'b0, 1'b1, 1'b1, pat[b], 1'b0, 4'(r)});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++)
          exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(r + 1)});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(rep)});
  endtask

  // called at a negedge; returns #1 after the edge that samples start
  task automatic start_tx(input logic [7:0] pat, input logic [3:0] len,
                          input logic [3:0] rep, input logic [2:0] gap);
    pattern = pat;
    pat_len = len;
    rep_cnt = rep;
    gap_len = gap;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    checks++;
    if (obs !== 9'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_init: got %b st=%0d exp %b st=0", obs, state_dbg, 9'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL reset_hold: got %b exp %b", obs, 9'b0);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    push_expected(8'h0A, 4, 1, 0);
    exp_q.push_back({5'b0, 4'd1});
    start_tx(8'h0A, 4'd4, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL single: got %b exp %b", obs, e);
      end
    end
  endtask

  task automatic test_repeat();
    int hits0;
    hits0 = det_hits;
    push_expected(8'h0A, 4, 3, 0);
    exp_q.push_back({5'b0, 4'd3});
    start_tx(8'h0A, 4'd4, 4'd3, 3'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL repeat: got %b exp %b", obs, e);
      end
    end
    checks++;
    if (det_hits - hits0 !== 5) begin
      failures++;
      $display("FAIL repeat_detector: got %0d hits exp 5", det_hits - hits0);
    end
  endtask

  task automatic test_gap();
    int busy_cycles;
    busy_cycles = 0;
    push_expected(8'h0A, 4, 2, 2);
    exp_q.push_back({5'b0, 4'd2});
    start_tx(8'h0A, 4'd4, 4'd2, 3'd2);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (busy) busy_cycles++;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL gap: got %b exp %b", obs, e);
      end
    end
    checks++;
    if (busy_cycles !== 10) begin
      failures++;
      $display("FAIL gap_busy_len: got %0d exp 10", busy_cycles);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] lens[3] = '{4'd0, 4'd9, 4'd4};
    logic [3:0] reps[3] = '{4'd1, 4'd1, 4'd0};
    for (int k = 0; k < 3; k++) begin
      start_tx(8'h0A, lens[k], reps[k], 3'd0);
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 4'b0, 4'd2} || state_dbg !== 2'd0) begin
        failures++;
        $display("FAIL illegal_%0d: got %b st=%0d exp %b st=0", k, obs, state_dbg,
                 {1'b1, 4'b0, 4'd2});
      end
      @(negedge clk);
      checks++;
      if (obs !== {5'b0, 4'd2}) begin
        failures++;
        $display("FAIL illegal_clear_%0d: got %b exp %b", k, obs, {5'b0, 4'd2});
      end
    end
  endtask

  task automatic test_restart_ignored();
    int i;
    i = 0;
    push_expected(8'h0A, 4, 2, 1);
    exp_q.push_back({5'b0, 4'd2});
    start_tx(8'h0A, 4'd4, 4'd2, 3'd1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL restart_ignored: got %b exp %b", obs, e);
      end
      if (i == 3) begin
        pattern = 8'hFF;
        pat_len = 4'd8;
        rep_cnt = 4'd5;
        gap_len = 3'd0;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_abort();
    logic [3:0] bits;
    int i;
    bits = 4'b1010;
    i = 0;
    for (int b = 3; b >= 0; b--) exp_q.push_back({3'b011, bits[b], 1'b0, 4'd0});
    for (int b = 3; b >= 1; b--) exp_q.push_back({3'b011, bits[b], 1'b0, 4'd1});
    exp_q.push_back({5'b0, 4'd1});
    exp_q.push_back({5'b0, 4'd1});
    start_tx(8'h0A, 4'd4, 4'd3, 3'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort: got %b exp %b", obs, e);
      end
      abort = (i == 6);
      i++;
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int i;
    i = 0;
    push_expected(8'h0A, 4, 1, 0);
    push_expected(8'h05, 3, 2, 0);
    exp_q.push_back({5'b0, 4'd2});
    start_tx(8'h0A, 4'd4, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back: got %b exp %b", obs, e);
      end
      if (i == 4) begin
        pattern = 8'h05;
        pat_len = 4'd3;
        rep_cnt = 4'd2;
        gap_len = 3'd0;
        start   = 1'b1;
        abort   = 1'b1;
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_pass();
    start_tx(8'h0A, 4'd4, 4'd3, 3'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: got %b st=%0d exp %b st=0", obs, state_dbg, 9'b0);
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL reset_mid_hold: got %b exp %b", obs, 9'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL reset_release: got %b exp %b", obs, 9'b0);
    end
    push_expected(8'hA5, 8, 1, 0);
    exp_q.push_back({5'b0, 4'd1});
    start_tx(8'hA5, 4'd8, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_recover_a5: got %b exp %b", obs, e);
      end
    end
  endtask

  initial begin
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    pat_len = '0;
    rep_cnt = '0;
    gap_len = '0;
    test_reset();
    test_single();
    test_repeat();
    test_gap();
    test_illegal();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
